// File: rtl/proc_pkg.sv
// Shared encodings for the bus-based processor: opcodes, ALU function codes
// and the control sequencer state encoding.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // Non-ALU opcodes map to ALU_ADD so the ALU input stays quiet.
  function automatic logic [2:0] alu_code(input logic [2:0] op);
    logic [2:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_OR:   code = ALU_OR;
      OP_SLT:  code = ALU_SLT;
      OP_SLL:  code = ALU_SLL;
      OP_SRL:  code = ALU_SRL;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit to 8-bit one-hot decoder with enable; all zeros when disabled.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] onehot
);

  // One-hot decode of sel, gated by en
  always_comb begin
    onehot = 8'h00;
    if (en) begin
      onehot[sel] = 1'b1;
    end else begin
      onehot = 8'h00;
    end
  end

endmodule

// File: rtl/proc_control.sv
// Multicycle control sequencer: fetches an instruction word and steps through
// T0..T3, decoding register, bus and ALU controls from state and ir.
module proc_control
  import proc_pkg::*;
#(
  parameter int NREGS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [8:0]       ir,
  output logic             ir_in,
  output logic [NREGS-1:0] r_in,
  output logic [NREGS-1:0] r_out,
  output logic             a_in,
  output logic             g_in,
  output logic             g_out,
  output logic             din_out,
  output logic [2:0]       alu_op,
  output logic             done
);

  logic [1:0] state_r;
  logic [1:0] next_state_s;
  logic [2:0] op_s;
  logic [7:0] x_hot_s;
  logic [7:0] y_hot_s;

  assign op_s = ir[8:6];

  dec3to8 u_dec_x (
    .en     (1'b1),
    .sel    (ir[5:3]),
    .onehot (x_hot_s)
  );

  dec3to8 u_dec_y (
    .en     (1'b1),
    .sel    (ir[2:0]),
    .onehot (y_hot_s)
  );

  // Output decode and next-state selection; reset silences every control
  always_comb begin
    next_state_s = state_r;
    ir_in        = 1'b0;
    r_in         = '0;
    r_out        = '0;
    a_in         = 1'b0;
    g_in         = 1'b0;
    g_out        = 1'b0;
    din_out      = 1'b0;
    alu_op       = 3'b000;
    done         = 1'b0;
    if (reset) begin
      next_state_s = T0;
    end else begin
      case (state_r)
        T0: begin
          if (run) begin
            ir_in        = 1'b1;
            next_state_s = T1;
          end else begin
            next_state_s = T0;
          end
        end
        T1: begin
          case (op_s)
            OP_MV: begin
              r_out        = y_hot_s;
              r_in         = x_hot_s;
              done         = 1'b1;
              next_state_s = T0;
            end
            OP_MVI: begin
              din_out      = 1'b1;
              r_in         = x_hot_s;
              done         = 1'b1;
              next_state_s = T0;
            end
            default: begin
              r_out        = x_hot_s;
              a_in         = 1'b1;
              next_state_s = T2;
            end
          endcase
        end
        T2: begin
          r_out        = y_hot_s;
          g_in         = 1'b1;
          alu_op       = alu_code(op_s);
          next_state_s = T3;
        end
        T3: begin
          g_out        = 1'b1;
          r_in         = x_hot_s;
          done         = 1'b1;
          next_state_s = T0;
        end
        default: begin
          next_state_s = T0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= T0;
    end else begin
      state_r <= next_state_s;
    end
  end

endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control: expected control vectors are queued as
// each cycle's stimulus is driven and compared against the DUT mid-cycle.
module tb_proc_control;

  logic       clock;
  logic       reset;
  logic       run;
  logic [8:0] ir;
  logic       ir_in;
  logic [7:0] r_in;
  logic [7:0] r_out;
  logic       a_in;
  logic       g_in;
  logic       g_out;
  logic       din_out;
  logic [2:0] alu_op;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [24:0] exp_q[$];

  proc_control #(.NREGS(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .ir      (ir),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .r_out   (r_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .din_out (din_out),
    .alu_op  (alu_op),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [24:0] mk(input logic iri, input logic [7:0] ri, input logic [7:0] ro,
                                     input logic ai, input logic gi, input logic go, input logic di,
                                     input logic [2:0] ao, input logic dn);
    return {iri, ri, ro, ai, gi, go, di, ao, dn};
  endfunction

  task automatic check_eq(input string tag, input logic [24:0] got, input logic [24:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare mid-cycle
  task automatic step(input string tag, input logic rst, input logic rn, input logic [8:0] w,
                      input logic [24:0] exp);
    logic [24:0] e;
    logic [24:0] obs;
    int busy;
    @(negedge clock);
    reset = rst;
    run   = rn;
    ir    = w;
    exp_q.push_back(exp);
    #2;
    obs  = {ir_in, r_in, r_out, a_in, g_in, g_out, din_out, alu_op, done};
    busy = $countones({r_out, g_out, din_out});
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, 25'd0, 25'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, obs, e);
    end
    check_eq({tag, "_bus"}, {24'd0, (busy <= 1)}, 25'd1);
  endtask

  // Expected per-cycle controls for one instruction, starting at its T0 fetch
  task automatic exec(input string tag, input logic [2:0] op, input logic [2:0] x,
                      input logic [2:0] y, input logic run_busy);
    logic [8:0] w;
    logic [7:0] xh;
    logic [7:0] yh;
    logic [2:0] ao;
    w  = {op, x, y};
    xh = 8'd1 << x;
    yh = 8'd1 << y;
    ao = op - 3'd2;
    step({tag, "_t0"}, 1'b0, 1'b1, w, mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    if (op == 3'b000) begin
      step({tag, "_t1"}, 1'b0, run_busy, w, mk(1'b0, xh, yh, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1));
    end else if (op == 3'b001) begin
      step({tag, "_t1"}, 1'b0, run_busy, w, mk(1'b0, xh, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1));
    end else begin
      step({tag, "_t1"}, 1'b0, run_busy, w, mk(1'b0, 8'h00, xh, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
      step({tag, "_t2"}, 1'b0, run_busy, w, mk(1'b0, 8'h00, yh, 1'b0, 1'b1, 1'b0, 1'b0, ao, 1'b0));
      step({tag, "_t3"}, 1'b0, run_busy, w, mk(1'b0, xh, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1));
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 9'd0, 25'd0);
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    ir    = 9'd0;

    step("rst_run", 1'b1, 1'b1, 9'b001_011_000, 25'd0);
    step("rst_hold", 1'b1, 1'b0, 9'd0, 25'd0);
    idle("post_rst0");
    idle("post_rst1");

    exec("mvi", 3'b001, 3'b011, 3'b000, 1'b0);
    idle("mvi_back_t0");

    exec("add", 3'b010, 3'b001, 3'b010, 1'b1);
    idle("add_idle");

    exec("srl", 3'b111, 3'b000, 3'b111, 1'b1);
    exec("sub", 3'b011, 3'b110, 3'b101, 1'b0);
    exec("or",  3'b100, 3'b010, 3'b100, 1'b1);
    exec("slt", 3'b101, 3'b111, 3'b011, 1'b0);
    exec("sll", 3'b110, 3'b100, 3'b001, 1'b1);
    idle("alu_idle");

    // mv X=Y with run held high, then add fetched without an idle cycle
    exec("b2b_mv", 3'b000, 3'b101, 3'b101, 1'b1);
    exec("b2b_add", 3'b010, 3'b011, 3'b110, 1'b1);
    idle("b2b_idle");

    // Reset lands in T2 of sub: nothing further may be issued
    step("abort_t0", 1'b0, 1'b1, 9'b011_010_001,
         mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    step("abort_t1", 1'b0, 1'b0, 9'b011_010_001,
         mk(1'b0, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    step("abort_rst", 1'b1, 1'b0, 9'b011_010_001, 25'd0);
    step("abort_after0", 1'b0, 1'b0, 9'b011_010_001, 25'd0);
    step("abort_after1", 1'b0, 1'b0, 9'b011_010_001, 25'd0);

    exec("mv_post", 3'b000, 3'b000, 3'b111, 1'b0);
    idle("final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_control.md
# proc_control

Multicycle control sequencer for the 16-bit bus-based processor. It fetches a 9-bit instruction word, then steps through the cycles of each instruction. Every cycle it drives the register-file load/output enables, the A and G register enables, the DIN bus enable and the 3-bit `alu_op` code for the ALU. It sits directly upstream of the ALU and owns the shared bus: it is the only block that decides which source drives the bus.

## Interface
Parameters:
- `NREGS`, 8: number of general registers; register fields are log2(`NREGS`) = 3 bits.

Ports:
- `clock` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: start request; sampled only in state T0.
- `ir` in 9: instruction register contents, format `III XXX YYY` (opcode, Rx, Ry); valid from T1 onward.
- `ir_in` out 1: load IR from DIN.
- `r_in` out 8: one-hot load enable for R0..R7.
- `r_out` out 8: one-hot bus drive for R0..R7.
- `a_in` out 1: load A from the bus.
- `g_in` out 1: load G from the ALU result.
- `g_out` out 1: G drives the bus.
- `din_out` out 1: DIN drives the bus (immediate).
- `alu_op` out 3: ALU function code.
- `done` out 1: one-cycle pulse in the final step of an instruction.

## Operation
- Opcodes: mv=000, mvi=001, add=010, sub=011, or=100, slt=101, sll=110, srl=111.
- ALU codes: add=000, sub=001, or=010, slt=011, sll=100, srl=101.
  - `alu_op` = opcode − 2 for opcodes 010..111; 000 otherwise.
- FSM states T0, T1, T2, T3; 2-bit state register.
- Outputs are combinational decodes of the state and `ir`. Every output not listed for a step is 0.
- T0: if `run`=1, then `ir_in`=1 and next state is T1. Otherwise all outputs are 0 and the FSM stays in T0.
- mv, T1:
  - `r_out[Y]`=1, `r_in[X]`=1, `done`=1; next state T0.
- mvi, T1:
  - `din_out`=1, `r_in[X]`=1, `done`=1; next state T0.
- ALU ops (add, sub, or, slt, sll, srl):
  - T1: `r_out[X]`=1, `a_in`=1; next state T2.
  - T2: `r_out[Y]`=1, `g_in`=1, `alu_op` per the mapping above; next state T3.
  - T3: `g_out`=1, `r_in[X]`=1, `done`=1; next state T0.
- `alu_op` is 000 in every state other than T2 of an ALU op.
- `run` is ignored in T1–T3; it does not abort or restart an instruction.
- Back-to-back execution: if `run`=1 in the T0 cycle right after `done`, the next fetch starts without an idle cycle.
- mv with X=Y is legal: register reads itself, no special case.
- Bus exclusivity invariant: at most one bit across {`r_out`, `g_out`, `din_out`} is set in any cycle.

## Timing
- Reset: a cycle with `reset`=1 forces all outputs to 0 in that cycle; the state is T0 at the next edge.
- Reset mid-instruction (T1–T3): the instruction is abandoned. No `r_in` or `done` is issued after the reset edge.
- Latency from `run` sampled in T0:
  - mv and mvi: `done` 1 cycle later (2 cycles total).
  - ALU ops: `done` 3 cycles later (4 cycles total).
- `done` is high for exactly one cycle per instruction, always in the same cycle as the final `r_in` pulse.
- `g_in` in T2 and `g_out` in T3 are in adjacent cycles; G holds the result for exactly one cycle before write-back.

## Structure
- Shared package `proc_pkg`:
  - opcode constants;
  - ALU code constants, which the ALU also imports;
  - state encoding T0–T3.
- Sub-module `dec3to8`: 3-bit to 8-bit one-hot decoder with enable, instantiated twice (X field, Y field).
- One sequential process for the state register; one combinational process for output decode.

## Test plan
- Reset check: reset=1 with run=1 → all outputs 0; after release with run=0, FSM stays in T0 and outputs stay 0.
- mvi, ir=001_011_000, run=1:
  - cycle 0: `ir_in`=1;
  - cycle 1: `din_out`=1, `r_in`=8'b0000_1000, `done`=1;
  - cycle 2: back in T0.
- add, ir=010_001_010:
  - T1: `r_out`=8'h02, `a_in`=1;
  - T2: `r_out`=8'h04, `g_in`=1, `alu_op`=000;
  - T3: `g_out`=1, `r_in`=8'h02, `done`=1.
- srl, ir=111_000_111: T2 gives `alu_op`=101 and `r_out`=8'h80. Repeat for sub→001, or→010, slt→011, sll→100.
- Back-to-back: mv then add with run held high → fetch of add occurs the cycle after mv `done`; total 6 cycles, two `done` pulses.
- Reset asserted in T2 of sub → outputs 0 that cycle, state T0 next, no `r_in`/`done` emitted. Bus-exclusivity assertion runs across all scenarios.
